// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI mode-0 slave transmitter, MSB-first on MISO, fed by a one-entry valid/ready buffer.
// i_sck/i_cs are synchronised into i_clk; words are reloaded at each boundary, or IDLE_BYTE on underrun.
module spi_slave_tx #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sck,
  input  logic                  i_cs,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_underrun
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                state_q, state_d;
  logic [2:0]            sck_q, sck_d, cs_q, cs_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, buf_q, buf_d, load_word;
  logic                  full_q, full_d, miso_q, miso_d, fresh_q, fresh_d;
  logic                  done_q, done_d, under_q, under_d;
  logic                  sck_rise, sck_fall, cs_fall, cs_rise, load, accept;
  // bits [1:0] are the 2-FF synchroniser, bit 2 is the edge-detect register
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign load      = (state_q == IDLE) ? cs_fall : (~cs_rise & sck_rise & (cnt_q == LAST));
  assign load_word = full_q ? buf_q : IDLE_BYTE;
  assign o_ready   = ~full_q & ~load;
  assign accept    = i_valid & o_ready;
  assign o_miso    = miso_q;
  assign o_miso_oe = (state_q == SHIFT);
  assign o_busy    = (state_q == SHIFT);
  assign o_done    = done_q;
  assign o_underrun = under_q;
  always_comb begin
    sck_d   = {sck_q[1:0], i_sck};
    cs_d    = {cs_q[1:0], i_cs};
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    miso_d  = miso_q;
    fresh_d = fresh_q;
    buf_d   = buf_q;
    full_d  = full_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d = SHIFT;
        cnt_d   = '0;
        fresh_d = 1'b0;
        miso_d  = load_word[DATA_WIDTH-1];
      end
    end else if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      fresh_d = 1'b0;
    end else if (sck_rise) begin
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      done_d  = (cnt_q == LAST);
      fresh_d = (cnt_q == LAST);
    end else if (sck_fall) begin
      // the first falling edge after a boundary reload presents the new MSB instead of shifting
      shreg_d = fresh_q ? shreg_q : shreg_q << 1;
      miso_d  = fresh_q ? shreg_q[DATA_WIDTH-1] : shreg_q[DATA_WIDTH-2];
      fresh_d = 1'b0;
    end
    if (load) begin
      shreg_d = load_word;
      under_d = ~full_q;
      full_d  = 1'b0;
    end
    if (accept) begin
      buf_d  = i_data;
      full_d = 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      sck_q   <= 3'b000;
      cs_q    <= 3'b111;
      cnt_q   <= '0;
      shreg_q <= IDLE_BYTE;
      buf_q   <= '0;
      full_q  <= 1'b0;
      miso_q  <= 1'b0;
      fresh_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      miso_q  <= miso_d;
      fresh_q <= fresh_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: drives SPI frames as a mode-0 master and checks MISO words and pulses against a word-level model.
module tb_spi_slave_tx;
  localparam logic [7:0] IDLE = 8'h00;
  logic clk = 1'b0, rst = 1'b0, sck = 1'b0, cs = 1'b1, valid = 1'b0;
  logic [7:0] data = '0;
  logic ready, miso, miso_oe, busy, done, under;
  int total = 0, bad = 0, n_done = 0, n_under = 0, exp_under = 0, rises = 0;
  logic [7:0] cur;
  logic [7:0] mbuf[$];
  logic [7:0] exp[$];
  logic [7:0] got[$];

  spi_slave_tx #(.DATA_WIDTH(8), .IDLE_BYTE(IDLE)) dut (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_cs(cs), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_miso(miso), .o_miso_oe(miso_oe), .o_busy(busy), .o_done(done), .o_underrun(under)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (done === 1'b1) n_done++;
    if (under === 1'b1) n_under++;
  end

  // model: each word boundary takes the buffered word if any, else IDLE with an underrun
  function automatic void boundary();
    if (mbuf.size() > 0) exp.push_back(mbuf.pop_front());
    else begin
      exp.push_back(IDLE);
      exp_under++;
    end
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
    end
    total++;
    if (k == 300) begin
      bad++;
      $display("FAIL push_timeout ready=%b want=1", ready);
    end
    valid = 1'b1;
    data = d;
    @(negedge clk);
    valid = 1'b0;
    mbuf.push_back(d);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    rises = 0;
    boundary();
    wait_clks(4);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs = 1'b1;
    if (exp.size() > 0) void'(exp.pop_back());
    wait_clks(4);
  endtask

  task automatic sck_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cur = {cur[6:0], miso};
      sck = 1'b1;
      rises++;
      if (rises % 8 == 0) begin
        got.push_back(cur);
        boundary();
      end
      wait_clks(4);
      sck = 1'b0;
      wait_clks(4);
    end
  endtask

  task automatic clear_frame();
    got.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    #3;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
    total++; if ({miso, miso_oe, busy, done, under} !== 5'b0) begin bad++; $display("FAIL rst_outs got=%b want=00000", {miso, miso_oe, busy, done, under}); end
    @(negedge clk);
    rst = 1'b1;
    wait_clks(3);
    total++; if ({ready, miso_oe, busy} !== 3'b100) begin bad++; $display("FAIL rst_release got=%b want=100", {ready, miso_oe, busy}); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int d0, u0, e0;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 8'hA5 : 8'($urandom);
      clear_frame();
      d0 = n_done;
      push(d);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_full got=%b want=0", ready); end
      u0 = n_under; e0 = exp_under;
      cs_low();
      total++; if ({ready, busy, miso_oe, miso} !== {3'b111, d[7]}) begin bad++; $display("FAIL single_start got=%b want=%b", {ready, busy, miso_oe, miso}, {3'b111, d[7]}); end
      sck_cycles(8);
      cs_high();
      total++; if (got.size() !== 1 || got[0] !== exp[0]) begin bad++; $display("FAIL single_word got=%h want=%h", got[0], exp[0]); end
      total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL single_done got=%0d want=1", n_done - d0); end
      total++; if (n_under - u0 !== exp_under - e0) begin bad++; $display("FAIL single_under got=%0d want=%0d", n_under - u0, exp_under - e0); end
      total++; if ({miso_oe, busy, miso} !== 3'b000) begin bad++; $display("FAIL single_end got=%b want=000", {miso_oe, busy, miso}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    int d0, u0, e0;
    a = 8'h3C; b = 8'hC3;
    for (int it = 0; it < 2; it++) begin
      if (it == 1) begin a = 8'($urandom); b = 8'($urandom); end
      clear_frame();
      d0 = n_done; u0 = n_under; e0 = exp_under;
      push(a);
      cs_low();
      push(b);
      sck_cycles(15);
      total++; if (n_under - u0 !== 0) begin bad++; $display("FAIL b2b_no_under got=%0d want=0", n_under - u0); end
      sck_cycles(1);
      cs_high();
      total++; if (got.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
        total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, got[i], exp[i]); end
      end
      total++; if (n_done - d0 !== 2) begin bad++; $display("FAIL b2b_done got=%0d want=2", n_done - d0); end
      total++; if (n_under - u0 !== exp_under - e0) begin bad++; $display("FAIL b2b_under got=%0d want=%0d", n_under - u0, exp_under - e0); end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] d;
    int u0, e0;
    d = 8'h81;
    clear_frame();
    u0 = n_under; e0 = exp_under;
    cs_low();
    total++; if (n_under - u0 !== 1) begin bad++; $display("FAIL under_csfall got=%0d want=1", n_under - u0); end
    sck_cycles(3);
    push(d);
    sck_cycles(13);
    cs_high();
    total++; if (got.size() !== 2) begin bad++; $display("FAIL under_count got=%0d want=2", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL under_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    total++; if (n_under - u0 !== exp_under - e0) begin bad++; $display("FAIL under_total got=%0d want=%0d", n_under - u0, exp_under - e0); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int d0;
    d = 8'($urandom);
    clear_frame();
    d0 = n_done;
    push(8'hF0);
    cs_low();
    sck_cycles(3);
    cs_high();
    total++; if ({miso, miso_oe, busy} !== 3'b000) begin bad++; $display("FAIL abort_outs got=%b want=000", {miso, miso_oe, busy}); end
    total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", n_done - d0); end
    total++; if (got.size() !== 0) begin bad++; $display("FAIL abort_words got=%0d want=0", got.size()); end
    for (int it = 0; it < 2; it++) begin
      clear_frame();
      push(it == 0 ? 8'h0F : d);
      cs_low();
      sck_cycles(8);
      cs_high();
      total++; if (got.size() !== 1 || got[0] !== exp[0]) begin bad++; $display("FAIL abort_next got=%h want=%h", got[0], exp[0]); end
    end
  endtask

  task automatic test_hold();
    logic [7:0] a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    clear_frame();
    push(a);
    cs_low();
    push(b);
    sck_cycles(3);
    fork
      begin
        int k;
        @(negedge clk);
        valid = 1'b1;
        data = c;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL hold_ready got=%b want=0", ready); end
        for (k = 0; k < 400; k++) begin
          @(negedge clk);
          if (ready === 1'b1) break;
        end
        total++; if (k == 400) begin bad++; $display("FAIL hold_timeout ready=%b want=1", ready); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL hold_accept_cycle done=%b want=1", done); end
        @(negedge clk);
        valid = 1'b0;
        mbuf.push_back(c);
      end
      sck_cycles(13);
    join
    sck_cycles(8);
    cs_high();
    total++; if (got.size() !== 3) begin bad++; $display("FAIL hold_count got=%0d want=3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL hold_word%0d got=%h want=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_async_reset();
    int u0, e0;
    clear_frame();
    push(8'h55);
    cs_low();
    push(8'($urandom));
    sck_cycles(4);
    #3 rst = 1'b0;
    #1;
    total++; if ({ready, miso, miso_oe, busy, done, under} !== 6'b100000) begin bad++; $display("FAIL arst_outs got=%b want=100000", {ready, miso, miso_oe, busy, done, under}); end
    cs = 1'b1;
    mbuf.delete();
    clear_frame();
    wait_clks(3);
    rst = 1'b1;
    wait_clks(3);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL arst_buf_lost got=%b want=1", ready); end
    u0 = n_under; e0 = exp_under;
    cs_low();
    total++; if (n_under - u0 !== exp_under - e0) begin bad++; $display("FAIL arst_under got=%0d want=%0d", n_under - u0, exp_under - e0); end
    sck_cycles(8);
    cs_high();
    total++; if (got.size() !== 1 || got[0] !== exp[0]) begin bad++; $display("FAIL arst_word got=%h want=%h", got[0], exp[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_tx.md
Name: spi_slave_tx

Overview:
SPI mode-0 slave transmitter that returns bytes from the FPGA to the Raspberry Pi master on MISO. It is the read-back path that complements the existing MOSI receive path. Internal logic, e.g. button or status reporting, hands bytes in through a one-entry valid/ready buffer. The block serialises them MSB-first while CS is low, and sends IDLE_BYTE when no data is waiting.

Parameters:
DATA_WIDTH, 8, bits per SPI word.
IDLE_BYTE, 8'h00, word shifted out when the buffer is empty at a word boundary.

Ports:
i_clk  input  1  system clock; must be at least 8x the SCK frequency (27 MHz clock allows SCK up to 3.375 MHz)
i_rst  input  1  asynchronous, active-low reset
i_sck  input  1  SPI clock from master, asynchronous, CPOL=0
i_cs  input  1  chip select from master, asynchronous, active-low
i_data  input  DATA_WIDTH  word to transmit
i_valid  input  1  i_data valid
o_ready  output  1  buffer empty; a word is accepted when i_valid and o_ready are both high on an i_clk edge
o_miso  output  1  serial data to master
o_miso_oe  output  1  MISO output enable; high while CS is active (synchronised)
o_busy  output  1  CS active (synchronised)
o_done  output  1  one-cycle pulse when a full word has been clocked out
o_underrun  output  1  one-cycle pulse when IDLE_BYTE is substituted

Behaviour:
- Reset (i_rst=0, asynchronous) drives:
  - buffer empty; o_ready=1
  - o_miso=0, o_miso_oe=0, o_busy=0, o_done=0, o_underrun=0
  - bit counter=0; shift register=IDLE_BYTE
  - synchroniser flops set to idle: sck=0, cs=1
- Synchronisation: i_sck and i_cs each pass through a 2-FF synchroniser plus one edge-detect register. Only the synchronised versions are used internally.
- Buffer:
  - buf_full is set on an accept.
  - buf_full is cleared when the shift register loads from the buffer.
  - o_ready = ~buf_full.
  - If load and i_valid occur in the same cycle, the load wins; o_ready is low that cycle and the new word is accepted on the following cycle.
- States: IDLE, SHIFT.
- IDLE to SHIFT on a synchronised CS falling edge, in the same cycle:
  - shift register loads the buffer, or IDLE_BYTE plus an o_underrun pulse if the buffer is empty
  - bit counter = 0
  - o_miso_oe = 1, o_busy = 1
  - o_miso presents the MSB on the next cycle, within 4 i_clk of the CS pin falling
- SHIFT, on each synchronised SCK rising edge (master samples here):
  - bit counter increments.
  - When the counter reaches DATA_WIDTH: o_done pulses, the counter wraps to 0, and the shift register reloads from the buffer (or IDLE_BYTE plus o_underrun).
- SHIFT, on each synchronised SCK falling edge: the shift register shifts left and o_miso takes the new MSB.
  - The falling edge that follows a reload does not shift; it presents the MSB of the freshly loaded word.
- SHIFT to IDLE on a synchronised CS rising edge, even mid-word:
  - a partial word is discarded, not resent, and no o_done is issued
  - bit counter = 0, o_miso = 0, o_miso_oe = 0, o_busy = 0
  - the buffer is untouched
- CS fall and SCK edge in the same cycle: the CS edge has priority and the SCK edge is ignored.
- SCK edges while in IDLE are ignored.
- Async reset mid-transfer: immediate return to the reset state; the buffered word is lost.
- Words per CS frame are unlimited; each word boundary consumes one buffered word or IDLE_BYTE.

Test Plan:
1. Load 8'hA5, assert CS, apply 8 SCK cycles -> master samples 1,0,1,0,0,1,0,1; exactly one o_done pulse; o_ready returns to 1 at the CS-fall load.
2. Load 8'h3C, then 8'hC3 once o_ready rises, then 16 SCK cycles in one CS frame -> samples 0x3C then 0xC3; two o_done pulses; no o_underrun.
3. Empty buffer, CS low, 8 SCK cycles -> samples 0x00 and one o_underrun pulse at CS fall. Loading 8'h81 mid-word is not sent until the next boundary; 8 more SCK cycles -> 0x81.
4. Load 8'hF0, CS low, 3 SCK cycles, CS high -> no o_done; o_miso=0 and o_miso_oe=0 within 4 i_clk. Load 8'h0F, new frame of 8 SCK cycles -> samples 0x0F.
5. Hold i_valid with the buffer full during a transfer -> o_ready=0 and no overwrite. The word is accepted on the cycle after the boundary load, and the first word is transmitted intact.
6. Assert i_rst during bit 4 of 8'h55 -> all outputs return to reset values immediately and o_ready=1. After release, CS low with an empty buffer -> IDLE_BYTE and o_underrun.
